// File: rtl/fp_sort_ctrl_pkg.sv
// Package fp: the shared floating-point types for the frame sorter.
//   float        - packed single-precision word {sign, exp, frac}
//   sort_state_e - LOAD / SORT / DRAIN controller states
//   mag_greater  - strict magnitude compare (exp, then frac), sign ignored
package fp;

  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exp;
    logic [FRACTION_BITS-1:0] frac;
  } float;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_e;

  // Exponent and fraction concatenate into one unsigned magnitude, so a
  // plain integer compare orders them. NaN/Inf are treated as huge values.
  function automatic logic mag_greater(input float x, input float y);
    return {x.exp, x.frac} > {y.exp, y.frac};
  endfunction

endpackage

// File: rtl/fp_sort_ctrl_sorter.sv
// fp_sorter: combinational compare-swap of two floats by magnitude.
//   a, b    - operands (a is the earlier slot in the buffer)
//   bign    - operand with the larger magnitude
//   smalln  - the other operand
// Ties keep a in bign, which is what makes the surrounding sort stable.
module fp_sorter
  import fp::*;
(
  input  float a,
  input  float b,
  output float bign,
  output float smalln
);

  always_comb begin
    bign   = a;
    smalln = b;
    if (mag_greater(b, a)) begin
      bign   = b;
      smalln = a;
    end
  end

endmodule

// File: rtl/fp_sort_ctrl.sv
// fp_sort_ctrl: loads a frame of up to DEPTH floats, bubble-sorts it in
// place by descending magnitude with one shared compare-swap unit, then
// streams the sorted frame out.
//   clock, reset          - single clock, synchronous active-high reset
//   in_valid/in_ready     - load handshake, in_data + in_last per entry
//   out_valid/out_ready   - drain handshake, out_data + out_last per entry
//   busy                  - high whenever the controller is not loading
module fp_sort_ctrl
  import fp::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  float in_data,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output float out_data,
  output logic out_last,
  output logic busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sort_state_e   state;
  sort_state_e   state_next;
  float          entries [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] j;
  logic [CW-1:0] rd;
  logic          swap_seen;

  logic [CW-1:0] count_plus1;
  logic [CW-1:0] j_plus1;
  float          cmp_a;
  float          cmp_b;
  float          bign;
  float          smalln;
  logic          swap_now;
  logic          pass_end;
  logic          load_fire;
  logic          drain_fire;

  assign count_plus1 = count + ONE;
  assign j_plus1     = j + ONE;
  assign cmp_a       = entries[j[IW-1:0]];
  assign cmp_b       = entries[j_plus1[IW-1:0]];
  assign swap_now    = (bign != cmp_a);
  assign pass_end    = (j == count - TWO);

  fp_sorter u_sorter (
    .a      (cmp_a),
    .b      (cmp_b),
    .bign   (bign),
    .smalln (smalln)
  );

  assign busy     = (state != LOAD);
  assign out_data = entries[rd[IW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // A one-entry frame is already sorted, so it skips SORT entirely.
  // SORT only leaves at the end of a pass that saw no swap at all,
  // including the compare happening on that final cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    load_fire  = 1'b0;
    drain_fire = 1'b0;
    case (state)
      LOAD: begin
        in_ready  = 1'b1;
        load_fire = in_valid;
        if (load_fire && (in_last || count_plus1 == FULL)) begin
          state_next = (count == '0) ? DRAIN : SORT;
        end
      end
      SORT: begin
        if (pass_end && !(swap_seen || swap_now)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid  = 1'b1;
        out_last   = (rd == count - ONE);
        drain_fire = out_ready;
        if (drain_fire && out_last) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Control counters. j and the swap flag are parked at zero while loading
  // so every SORT phase starts a fresh pass at slot 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      j         <= '0;
      rd        <= '0;
      swap_seen <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          j         <= '0;
          rd        <= '0;
          swap_seen <= 1'b0;
          if (load_fire) begin
            count <= count_plus1;
          end
        end
        SORT: begin
          if (pass_end) begin
            j         <= '0;
            swap_seen <= 1'b0;
          end else begin
            j         <= j_plus1;
            swap_seen <= swap_seen | swap_now;
          end
        end
        DRAIN: begin
          if (drain_fire) begin
            if (out_last) begin
              count <= '0;
              rd    <= '0;
            end else begin
              rd <= rd + ONE;
            end
          end
        end
        default: begin
          count     <= '0;
          j         <= '0;
          rd        <= '0;
          swap_seen <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage has no reset; a discarded frame is simply overwritten.
  // Writing bign/smalln back unconditionally is harmless when no swap occurs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == LOAD && load_fire) begin
        entries[count[IW-1:0]] <= in_data;
      end else if (state == SORT) begin
        entries[j[IW-1:0]]       <= bign;
        entries[j_plus1[IW-1:0]] <= smalln;
      end
    end
  end

endmodule

// File: tb/tb_fp_sort_ctrl.sv
// Self-checking bench for fp_sort_ctrl: directed frames, a stable-sort
// reference model, and one negedge compare process on the drain stream.
module tb_fp_sort_ctrl;
  import fp::*;

  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  float in_data;
  logic in_last;
  logic out_valid;
  logic out_ready;
  float out_data;
  logic out_last;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];
  int          drain_idx = 0;
  int          exp_sort_cycles = 0;

  always #5 clock = ~clock;

  fp_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [30:0] mag(input logic [31:0] v);
    return v[30:0];
  endfunction

  // Reference: stable descending-magnitude order by insertion, and the
  // bubble-sort pass count from the largest number of strictly smaller
  // entries sitting ahead of any entry (each pass moves it one slot),
  // plus one final clean pass.
  task automatic buildModel();
    logic [31:0] s[$];
    int pos;
    int worst;
    int ahead;
    int n;
    s = {};
    worst = 0;
    n = stim_q.size();
    for (int i = 0; i < n; i++) begin
      pos = s.size();
      while (pos > 0 && mag(s[pos-1]) < mag(stim_q[i])) pos--;
      s.insert(pos, stim_q[i]);
      ahead = 0;
      for (int k = 0; k < i; k++) begin
        if (mag(stim_q[k]) < mag(stim_q[i])) ahead++;
      end
      if (ahead > worst) worst = ahead;
    end
    exp_q = s;
    drain_idx = 0;
    exp_sort_cycles = (n < 2) ? 0 : (worst + 1) * (n - 1);
  endtask

  task automatic applyStimulus(input bit with_last);
    bit acc;
    int guard;
    for (int i = 0; i < stim_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = stim_q[i];
      in_last  = with_last && (i == stim_q.size() - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        #1;
        guard++;
      end
      if (!acc) checkOutput("load_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    buildModel();
  endtask

  task automatic measureSort(input string name);
    int cyc;
    cyc = 0;
    checkOutput({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
    checkOutput({name, "_busy_high"}, 32'(busy), 32'd1);
    while (!out_valid && cyc < 400) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    checkOutput({name, "_sort_cycles"}, 32'(cyc), 32'(exp_sort_cycles));
  endtask

  task automatic drainFrame(input string name, input bit random_ready);
    int cyc;
    cyc = 0;
    while (drain_idx < exp_q.size() && cyc < 400) begin
      out_ready = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clock);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput({name, "_drained"}, 32'(drain_idx), 32'(exp_q.size()));
    checkOutput({name, "_back_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_back_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_back_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Every valid drain cycle is compared against the model; the index only
  // moves when a handshake will happen on the coming edge, so a held entry
  // is re-checked each stalled cycle.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (drain_idx < exp_q.size()) begin
        checkOutput($sformatf("out_data[%0d]", drain_idx), out_data, exp_q[drain_idx]);
        checkOutput($sformatf("out_last[%0d]", drain_idx), 32'(out_last),
                    32'(drain_idx == exp_q.size() - 1));
        if (out_ready) drain_idx++;
      end else begin
        checkOutput("out_valid_unexpected", 32'(out_valid), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_last", 32'(out_last), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Mixed signs, unsorted, closed by in_last.
    stim_q = '{32'h3F800000, 32'hC0400000, 32'h3F000000, 32'h40000000};
    applyStimulus(1'b1);
    checkOutput("pin4_e0", exp_q[0], 32'hC0400000);
    checkOutput("pin4_e1", exp_q[1], 32'h40000000);
    checkOutput("pin4_e2", exp_q[2], 32'h3F800000);
    checkOutput("pin4_e3", exp_q[3], 32'h3F000000);
    checkOutput("pin4_cycles", 32'(exp_sort_cycles), 32'd9);
    measureSort("frame4");
    drainFrame("frame4", 1'b0);

    // Full frame already descending, no in_last: one clean pass only.
    stim_q = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
               32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    applyStimulus(1'b0);
    checkOutput("pin8_cycles", 32'(exp_sort_cycles), 32'd7);
    checkOutput("pin8_e0", exp_q[0], 32'h41000000);
    measureSort("frame8");
    drainFrame("frame8", 1'b1);

    // Single entry goes straight to DRAIN.
    stim_q = '{32'h3F800000};
    applyStimulus(1'b1);
    checkOutput("pin1_cycles", 32'(exp_sort_cycles), 32'd0);
    measureSort("frame1");
    drainFrame("frame1", 1'b0);

    // Equal magnitudes, opposite signs: order must be kept.
    stim_q = '{32'h40000000, 32'hC0000000};
    applyStimulus(1'b1);
    checkOutput("pin2_e0", exp_q[0], 32'h40000000);
    checkOutput("pin2_e1", exp_q[1], 32'hC0000000);
    measureSort("frame2");
    drainFrame("frame2", 1'b1);

    // Ascending frame needs many passes; reset lands mid-sort.
    stim_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    applyStimulus(1'b0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checkOutput("midsort_busy", 32'(busy), 32'd1);
    exp_q = {};
    drain_idx = 0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst_sort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_sort_busy", 32'(busy), 32'd0);
    checkOutput("rst_sort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sort_out_last", 32'(out_last), 32'd0);

    // Fresh frame after the reset, with a tie and a zero.
    stim_q = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'h00000000, 32'h3F000000};
    applyStimulus(1'b1);
    checkOutput("pin5_e0", exp_q[0], 32'h40400000);
    checkOutput("pin5_e1", exp_q[1], 32'h3F800000);
    checkOutput("pin5_e2", exp_q[2], 32'hBF800000);
    checkOutput("pin5_e4", exp_q[4], 32'h00000000);
    measureSort("frame5");
    drainFrame("frame5", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_sort_ctrl.md
FP_SORT_CTRL -- requirements
Module: fp_sort_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the maximum number of entries per frame (2..16).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-006 SHALL have port in_data, input, fp::float, the operand being loaded.
REQ-007 SHALL have port in_last, input, 1, meaning in_data is the final entry of the frame.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes out_data.
REQ-010 SHALL have port out_data, output, fp::float, the sorted entry.
REQ-011 SHALL have port out_last, output, 1, meaning out_data is the final entry of the frame.
REQ-012 SHALL have port busy, output, 1, asserted whenever the state is not LOAD.

Function
REQ-013 SHALL implement a three-state FSM: LOAD, SORT, DRAIN.
REQ-014 LOAD: in_ready=1; on in_valid&&in_ready, write in_data to buf[count] and increment count.
REQ-015 LOAD exit: on accepting an entry with in_last=1, or the entry that makes count==DEPTH, go to SORT next cycle (DRAIN if count==1); in_ready=0 from that next cycle.
REQ-016 Ordering: descending magnitude (exp, then frac), sign ignored, exactly as decided by one fp_sorter instance; NaN/Inf get no special handling.
REQ-017 SORT: one compare-swap per cycle; fp_sorter a=buf[j], b=buf[j+1]; write buf[j]=bign, buf[j+1]=smalln; j runs 0..count-2, then wraps to 0.
REQ-018 A swap is flagged when bign differs from buf[j]; equal magnitudes never swap, so the sort is stable.
REQ-019 At j==count-2: if no swap occurred in the pass (including this cycle), go to DRAIN next cycle; otherwise clear the flag and start a new pass.
REQ-020 A pass SHALL take exactly count-1 cycles; an already-sorted frame spends exactly count-1 cycles in SORT.
REQ-021 DRAIN: out_valid=1, out_data=buf[rd], out_last=(rd==count-1); rd advances only on out_valid&&out_ready.
REQ-022 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On the handshake of the out_last entry, return to LOAD next cycle with count=0 and rd=0; in_ready=1 that cycle.
REQ-024 in_valid SHALL be ignored outside LOAD; out_ready SHALL be ignored outside DRAIN.

Reset
REQ-025 While reset=1 at a clock edge: state=LOAD, count=0, j=0, rd=0, swap flag=0; the next cycle has in_ready=1, out_valid=0, out_last=0, busy=0.
REQ-026 Reset mid-SORT or mid-DRAIN SHALL discard the frame; buf contents need not be cleared.

Structure
REQ-027 The float typedef, EXPONENT_BITS, FRACTION_BITS and the sort-state enum typedef SHALL live in package fp.
REQ-028 SHALL instantiate exactly one fp_sorter sub-module, time-shared across all compare-swaps.
REQ-029 Counters SHALL be $clog2(DEPTH+1) bits wide.

Verification
REQ-030 Load 0x3F800000, 0xC0400000, 0x3F000000, 0x40000000 (last on the 4th) -> drain 0xC0400000, 0x40000000, 0x3F800000, 0x3F000000, out_last on the 4th.
REQ-031 Load 8 descending values with no in_last -> in_ready drops after the 8th; exactly 7 SORT cycles; drain in input order.
REQ-032 Load a single 0x3F800000 with in_last -> zero SORT cycles; out_valid the cycle after in_ready drops; out_last=1.
REQ-033 Load 0x40000000 then 0xC0000000 (last) -> drain 0x40000000 then 0xC0000000 (stable).
REQ-034 Toggle out_ready randomly in DRAIN -> each entry held until accepted, none lost or duplicated.
REQ-035 Assert reset during SORT -> next cycle in_ready=1, busy=0, out_valid=0; a new frame sorts correctly.
